// File: rtl/ap3_ram_pkg.sv
// Shared constants for the AP3 embedded RAM port: address/data widths and width-mode encodings.
// Latency: none (package only).
// Backpressure: not applicable.
package ap3_ram_pkg;

  localparam int RAM_AW = 11;
  localparam int RAM_DW = 32;

  // RMODE/WMODE port-width selection of the RAM macro.
  typedef enum logic [1:0] {
    MODE_X32 = 2'b00,
    MODE_X16 = 2'b01,
    MODE_X8  = 2'b10,
    MODE_X4  = 2'b11
  } ram_mode_e;

  // FMODE = 0 selects plain RAM behaviour (not the macro's built-in FIFO).
  localparam logic FMODE_RAM = 1'b0;

endpackage

// File: rtl/ram_fifo_outq.sv
// Two-entry prefetch queue sitting between the RAM read port and the downstream handshake.
// Latency: a word enqueued this cycle is at head the next cycle.
// Backpressure: none internally; the caller guarantees enq never hits a full queue and pop never hits an empty one.
// Ports: CLK, RST_N (sync active-low), flush (sync clear), enq/data (write), pop (remove head), occ (0..2), head (oldest word).
module ram_fifo_outq
  import ap3_ram_pkg::*;
#(
  parameter int DW = RAM_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          flush,
  input  logic          enq,
  input  logic [DW-1:0] data,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] q0;
  logic [DW-1:0] q1;

  // q0 is always the head; q1 is only meaningful when occ == 2.
  always_ff @(posedge CLK) begin
    if (!RST_N || flush) begin
      occ <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      case ({enq, pop})
        2'b10: begin
          if (occ == 2'd0) q0 <= data;
          else             q1 <= data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever survives the pop.
          if (occ == 2'd1) begin
            q0 <= data;
          end else begin
            q0 <= q1;
            q1 <= data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = q0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external single-clock RAM with 1-cycle read latency, plus a 2-word prefetch queue.
// Latency: push in cycle 0 into an empty block gives OUT_VALID in cycle 3; one word per cycle sustained.
// Backpressure: IN_READY drops when the RAM region is full or during FLUSH/reset; OUT_READY low stalls reads once the queue is claimed.
// Ports: CLK, RST_N, FLUSH; IN_VALID/IN_READY/IN_DATA push side; OUT_VALID/OUT_READY/OUT_DATA pop side;
//        WADDR/WDATA/WEN and RADDR/REN/RDATA to the RAM; RMODE/WMODE/FMODE ties; COUNT and status flags.
module ram_fifo_ctrl
  import ap3_ram_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int AE_THRESH = 4,
  parameter int AF_THRESH = (1 << ADDR_W) - 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [RAM_DW-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [RAM_DW-1:0] OUT_DATA,
  output logic [RAM_AW-1:0] WADDR,
  output logic [RAM_DW-1:0] WDATA,
  output logic              WEN,
  output logic [RAM_AW-1:0] RADDR,
  output logic              REN,
  input  logic [RAM_DW-1:0] RDATA,
  output logic [1:0]        RMODE,
  output logic [1:0]        WMODE,
  output logic              FMODE,
  output logic [ADDR_W+1:0] COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_EMPTY,
  output logic              ALMOST_FULL
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              pend;
  logic [1:0]        outq_occ;
  logic              clr;
  logic              ram_full;
  logic              push;
  logic              pop;
  logic [2:0]        outq_claim;

  // Reset and flush share one clear path; both discard a read in flight.
  assign clr      = !RST_N || FLUSH;
  assign ram_full = (ram_cnt == DEPTH_CNT);
  assign IN_READY = !ram_full && !clr;
  assign push     = IN_VALID && IN_READY;

  assign OUT_VALID = (outq_occ != 2'd0);
  assign pop       = OUT_VALID && OUT_READY;

  // Queue slots already spoken for at the end of this cycle: stored words plus the
  // read landing now, less the word leaving. A new read may only start if a slot is left.
  assign outq_claim = {1'b0, outq_occ} + {2'b00, pend} - {2'b00, pop};
  assign REN        = (ram_cnt != '0) && (outq_claim < 3'd2) && !clr;

  always_ff @(posedge CLK) begin
    if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (REN)  rptr <= rptr + ADDR_W'(1);
      case ({push, REN})
        2'b10:   ram_cnt <= ram_cnt + (ADDR_W + 1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (ADDR_W + 1)'(1);
        default: ;
      endcase
      pend <= REN;
    end
  end

  ram_fifo_outq #(
    .DW (RAM_DW)
  ) u_outq (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (FLUSH),
    .enq   (pend),
    .data  (RDATA),
    .pop   (pop),
    .occ   (outq_occ),
    .head  (OUT_DATA)
  );

  assign WEN   = push;
  assign WADDR = RAM_AW'(wptr);
  assign WDATA = IN_DATA;
  assign RADDR = RAM_AW'(rptr);

  assign RMODE = MODE_X32;
  assign WMODE = MODE_X32;
  assign FMODE = FMODE_RAM;

  assign COUNT        = (ADDR_W + 2)'(ram_cnt) + (ADDR_W + 2)'(outq_occ) + (ADDR_W + 2)'(pend);
  assign EMPTY        = (COUNT == '0);
  assign FULL         = ram_full;
  assign ALMOST_EMPTY = (int'(COUNT) <= AE_THRESH);
  assign ALMOST_FULL  = (int'(ram_cnt) >= AF_THRESH);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a small RAM model and a queue-based reference of the FIFO contents.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised with directed fill/drain, streaming, random handshakes, and mid-stream flush/reset.
module tb_ram_fifo_ctrl;
  import ap3_ram_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AE    = 4;
  localparam int AF    = DEPTH - 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [10:0] WADDR;
  logic [31:0] WDATA;
  logic        WEN;
  logic [10:0] RADDR;
  logic        REN;
  logic [31:0] RDATA;
  logic [1:0]  RMODE;
  logic [1:0]  WMODE;
  logic        FMODE;
  logic [AW+1:0] COUNT;
  logic        EMPTY;
  logic        FULL;
  logic        ALMOST_EMPTY;
  logic        ALMOST_FULL;

  always #5 CLK = ~CLK;

  ram_fifo_ctrl #(
    .ADDR_W (AW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .FLUSH        (FLUSH),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .IN_DATA      (IN_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_DATA     (OUT_DATA),
    .WADDR        (WADDR),
    .WDATA        (WDATA),
    .WEN          (WEN),
    .RADDR        (RADDR),
    .REN          (REN),
    .RDATA        (RDATA),
    .RMODE        (RMODE),
    .WMODE        (WMODE),
    .FMODE        (FMODE),
    .COUNT        (COUNT),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .ALMOST_FULL  (ALMOST_FULL)
  );

  // Synchronous RAM, read data valid the cycle after REN.
  logic [31:0] ram_mem [0:2047];
  always @(posedge CLK) begin
    if (WEN) ram_mem[WADDR] <= WDATA;
    if (REN) RDATA <= ram_mem[RADDR];
  end

  int          total = 0;
  int          bad   = 0;
  bit          live  = 1'b0;
  logic [31:0] mdl[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, update the reference, return just after the next rising edge.
  task automatic tick();
    logic [31:0] exp_d;
    bit          clr;
    @(negedge CLK);
    clr = !RST_N || FLUSH;
    if (live) begin
      check_eq("count",    COUNT, mdl.size());
      check_eq("empty",    EMPTY, mdl.size() == 0);
      check_eq("aempty",   ALMOST_EMPTY, mdl.size() <= AE);
      check_eq("wen",      WEN, IN_VALID && IN_READY);
      check_eq("waddr_hi", WADDR >> AW, 0);
      check_eq("raddr_hi", RADDR >> AW, 0);
      check_eq("outq_occ", dut.u_outq.occ <= 2'd2, 1);
      if (mdl.size() == 0) check_eq("ovld_when_empty", OUT_VALID, 0);
      if (mdl.size() < AF) check_eq("afull_low", ALMOST_FULL, 0);
      if (clr) begin
        check_eq("rdy_in_clear", IN_READY, 0);
      end else if (mdl.size() < DEPTH) begin
        check_eq("rdy_not_full", IN_READY, 1);
        check_eq("full_low", FULL, 0);
      end else if (mdl.size() == DEPTH + 2) begin
        check_eq("rdy_at_max", IN_READY, 0);
        check_eq("full_at_max", FULL, 1);
      end
      if (FLUSH) check_eq("ren_in_flush", REN, 0);
    end
    if (clr) begin
      mdl.delete();
    end else begin
      if (OUT_VALID && OUT_READY && mdl.size() != 0) begin
        exp_d = mdl.pop_front();
        check_eq("data", OUT_DATA, exp_d);
      end
      if (IN_VALID && IN_READY) mdl.push_back(IN_DATA);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_midstream(input bit use_rst);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = 32'hA000_0000 + i;
      tick();
    end
    check_eq("pre_count7", COUNT, 7);
    // Push and pop together so COUNT holds at 7 while a RAM read goes in flight.
    IN_DATA   = 32'hA000_0007;
    OUT_READY = 1'b1;
    #1;
    check_eq("pre_ren", REN, 1);
    tick();
    check_eq("inflight_count", COUNT, 7);
    if (use_rst) RST_N = 1'b0;
    else         FLUSH = 1'b1;
    IN_DATA = 32'hBAD0_0000;
    tick();
    RST_N    = 1'b1;
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    #1;
    check_eq("clr_count", COUNT, 0);
    check_eq("clr_ovld", OUT_VALID, 0);
    check_eq("clr_rdy", IN_READY, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("no_stale", OUT_VALID, 0);
    end
    IN_VALID = 1'b1;
    IN_DATA  = 32'hC0DE_0000 + 32'(use_rst);
    tick();
    IN_VALID = 1'b0;
    repeat (6) tick();
    check_eq("post_clr_drained", COUNT, 0);
    check_eq("post_clr_model", mdl.size(), 0);
  endtask

  initial begin
    int got;
    RST_N     = 1'b0;
    FLUSH     = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    OUT_READY = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    live  = 1'b1;
    #1;
    check_eq("rst_count",  COUNT, 0);
    check_eq("rst_empty",  EMPTY, 1);
    check_eq("rst_aempty", ALMOST_EMPTY, 1);
    check_eq("rst_full",   FULL, 0);
    check_eq("rst_afull",  ALMOST_FULL, 0);
    check_eq("rst_ovld",   OUT_VALID, 0);
    check_eq("rst_wen",    WEN, 0);
    check_eq("rst_ren",    REN, 0);
    check_eq("rst_rdy",    IN_READY, 1);
    check_eq("rmode",      RMODE, MODE_X32);
    check_eq("wmode",      WMODE, MODE_X32);
    check_eq("fmode",      FMODE, 0);

    // Single word latency.
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    IN_DATA   = 32'hDEAD_BEEF;
    tick();
    IN_VALID = 1'b0;
    check_eq("lat_c1", OUT_VALID, 0);
    tick();
    check_eq("lat_c2", OUT_VALID, 0);
    tick();
    check_eq("lat_c3", OUT_VALID, 1);
    check_eq("lat_c3_data", OUT_DATA, 32'hDEAD_BEEF);
    tick();
    check_eq("lat_c4_empty", EMPTY, 1);

    // Fill with the output blocked: the queue takes two words, the RAM sixteen.
    // Two reads start in cycles 1 and 2, so RAM holds i-2 words from cycle 3 on;
    // it reaches the almost-full mark of 12 at cycle 14.
    OUT_READY = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq("fill_afull", ALMOST_FULL, i >= 14);
      IN_VALID = 1'b1;
      IN_DATA  = 32'(i);
      tick();
    end
    IN_VALID = 1'b0;
    #1;
    check_eq("fill_count", COUNT, 18);
    check_eq("fill_full",  FULL, 1);
    check_eq("fill_rdy",   IN_READY, 0);
    check_eq("fill_afull_end", ALMOST_FULL, 1);
    OUT_READY = 1'b1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (OUT_VALID) begin
        check_eq("drain_data", OUT_DATA, got);
        got++;
      end
      tick();
    end
    check_eq("drain_n", got, 18);
    check_eq("drain_empty", EMPTY, 1);

    // Streaming: one word per cycle after three cycles of fill, across many pointer wraps.
    OUT_READY = 1'b1;
    for (int c = 0; c < 1006; c++) begin
      check_eq("stream_vld", OUT_VALID, (c >= 3) && (c < 1003));
      IN_VALID = (c < 1000);
      IN_DATA  = 32'h1000_0000 + 32'(c);
      tick();
    end
    IN_VALID = 1'b0;
    check_eq("stream_model", mdl.size(), 0);

    // Random handshakes on both sides.
    for (int c = 0; c < 2000; c++) begin
      IN_VALID  = ($urandom_range(0, 99) < 60);
      OUT_READY = ($urandom_range(0, 99) < 50);
      IN_DATA   = $urandom;
      tick();
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (25) tick();
    check_eq("rand_drained", COUNT, 0);
    check_eq("rand_model", mdl.size(), 0);

    clear_midstream(1'b0);
    clear_midstream(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set RAM words used (DEPTH = 2**ADDR_W), legal range 1..11.
REQ-002 Parameter AE_THRESH, default 4, SHALL set the almost-empty threshold on COUNT.
REQ-003 Parameter AF_THRESH, default DEPTH-4, SHALL set the almost-full threshold on RAM occupancy.
REQ-004 CLK  in  1  sole clock; all state on rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 FLUSH  in  1  synchronous clear of all contents.
REQ-007 IN_VALID / IN_READY / IN_DATA  in / out / in  1/1/32  upstream push handshake.
REQ-008 OUT_VALID / OUT_READY / OUT_DATA  out / in / out  1/1/32  downstream pop handshake.
REQ-009 WADDR / WDATA / WEN  out  11/32/1  RAM write port.
REQ-010 RADDR / REN  out  11/1  RAM read port; RDATA  in  32  RAM read data, valid the cycle after REN.
REQ-011 RMODE, WMODE  out  2  SHALL be tied to the 32-bit mode constant; FMODE  out  1  SHALL be tied to 0 (RAM mode).
REQ-012 COUNT  out  ADDR_W+2  total words held; EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL  out  1 each.

Function
REQ-013 Push SHALL occur when IN_VALID & IN_READY; pop SHALL occur when OUT_VALID & OUT_READY.
REQ-014 WEN SHALL equal push combinationally, with WADDR = write pointer and WDATA = IN_DATA; write pointer SHALL increment mod DEPTH on push.
REQ-015 WADDR/RADDR bits above ADDR_W-1 SHALL be 0.
REQ-016 ram_cnt (0..DEPTH) SHALL track words in RAM: +1 on push, -1 on REN, unchanged when both occur.
REQ-017 IN_READY SHALL be !(ram_cnt == DEPTH) & !FLUSH; FULL SHALL equal (ram_cnt == DEPTH).
REQ-018 A 2-entry output queue SHALL hold prefetched words; OUT_VALID = queue non-empty; OUT_DATA = queue head.
REQ-019 pend SHALL be a register set to REN of the previous cycle; when pend = 1 RDATA SHALL be enqueued at the cycle end.
REQ-020 REN SHALL assert iff ram_cnt > 0 and (outq_occ + pend - pop) < 2 and !FLUSH; RADDR = read pointer, incremented mod DEPTH on REN.
REQ-021 The queue SHALL never overflow; simultaneous enqueue and pop SHALL keep occupancy constant.
REQ-022 Latency: a push accepted in cycle 0 into an empty block SHALL produce OUT_VALID = 1 in cycle 3.
REQ-023 Sustained throughput SHALL be one word per cycle when OUT_READY is held high and IN_VALID is held high.
REQ-024 COUNT SHALL equal ram_cnt + outq_occ + pend; EMPTY = (COUNT == 0); ALMOST_EMPTY = (COUNT <= AE_THRESH); ALMOST_FULL = (ram_cnt >= AF_THRESH).
REQ-025 Order SHALL be strict FIFO; pointer wrap DEPTH-1 -> 0 SHALL be seamless.
REQ-026 FLUSH = 1 SHALL clear pointers, ram_cnt, queue and pend at the cycle end; a concurrent push or pop SHALL be ignored; an in-flight RDATA SHALL be discarded.

Reset
REQ-027 When RST_N = 0 at a rising edge, the block SHALL reach the flush state: COUNT = 0, EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0, OUT_VALID = 0, WEN = 0, REN = 0, IN_READY = 1 on the next cycle.
REQ-028 IN_READY SHALL be 0 while RST_N = 0.
REQ-029 Reset mid-operation SHALL discard all data, including a pending read.
REQ-030 No asynchronous reset and no initial-value dependence SHALL exist.

Structure
REQ-031 Package ap3_ram_pkg SHALL hold RAM_AW = 11, RAM_DW = 32 and the RMODE/WMODE width-mode encodings, including MODE_X32.
REQ-032 The 2-entry output queue SHALL be sub-module ram_fifo_outq (enq, data, pop, occ, head), with the same clock and reset.
REQ-033 The block SHALL contain no RAM model and SHALL instantiate no RAM.

Verification
REQ-034 Single word: push 0xDEADBEEF in cycle 0 with OUT_READY = 1 -> OUT_VALID in cycle 3 with OUT_DATA = 0xDEADBEEF, then EMPTY = 1 in cycle 4.
REQ-035 Fill: ADDR_W = 4, OUT_READY = 0, push 0..19 -> 18 accepted, COUNT = 18, FULL = 1, IN_READY = 0, ALMOST_FULL from ram_cnt = 12; then drain -> 0..17 in order.
REQ-036 Streaming: 1000 incrementing words with IN_VALID = OUT_READY = 1 -> one output per cycle after a 3-cycle fill, no gaps, no loss, with pointers wrapping.
REQ-037 Backpressure: random OUT_READY (50%) and random IN_VALID -> the output sequence equals the input sequence, and outq_occ never exceeds 2.
REQ-038 Flush/reset mid-stream: with COUNT = 7 and REN = 1, assert FLUSH (then repeat with RST_N = 0) for one cycle -> next cycle COUNT = 0, OUT_VALID = 0, and stale RDATA is never output.
